// File: rtl/id_ex_hazard_controller_pkg.sv
// Shared types and constants for the ID/EX hazard controller slice.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        FREEZE,
        HALT
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/id_ex_hazard_controller_if.sv
// Pipeline-side signal bundle of the ID/EX hazard controller.
// master: the pipeline that supplies operand/hazard info and consumes enables.
// slave : the controller itself.
interface id_ex_hazard_controller_if #(
    parameter int unsigned CNT_W = 16
);

    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_write_en;
    logic             id_ex_bubble;
    logic             ex_mem_write_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, branch_taken, mem_busy,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_bubble, ex_mem_write_en, halted, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_rd, ex_mem_read, branch_taken, mem_busy,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_bubble, ex_mem_write_en, halted, stall_cycles, flush_count
    );

endinterface

// File: rtl/id_ex_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_hazard_controller.sv
// ID/EX hazard controller: load-use stalls, taken-branch flushes and
// data-memory freezes with timeout into a sticky HALT state.
module id_ex_hazard_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    id_ex_hazard_controller_if.slave    bus
);

    hz_state_t  state, next_state;
    logic       branch_pending, next_pending;
    logic [7:0] fz_cnt, next_fz_cnt;

    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    logic       pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_bub, ex_mem_we;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Load-use hazard: EX load writes a register the ID instruction reads.
    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) &&
                   ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                    (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    end

    // State, pending-branch flag and freeze timeout register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            branch_pending <= 1'b0;
            fz_cnt         <= '0;
        end else begin
            state          <= next_state;
            branch_pending <= next_pending;
            fz_cnt         <= next_fz_cnt;
        end
    end

    // Next-state and enable/flush/bubble decode.
    // A FREEZE cycle with mem_busy low falls through to the RUN rules, so a
    // branch latched during the freeze is flushed in that same cycle.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_fl     = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_bub    = 1'b0;
        ex_mem_we    = 1'b1;
        next_state   = state;
        next_pending = branch_pending;
        next_fz_cnt  = fz_cnt;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (state == HALT) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (bus.mem_busy) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            if (bus.branch_taken) begin
                next_pending = 1'b1;
            end
            if (state == RUN) begin
                next_state  = FREEZE;
                next_fz_cnt = 8'd1;
            end else begin
                stall_inc = 1'b1;
                if (fz_cnt == 8'(MEM_TIMEOUT)) begin
                    next_state = HALT;
                end else begin
                    next_fz_cnt = fz_cnt + 8'd1;
                end
            end
        end else begin
            if (state == FREEZE) begin
                stall_inc   = 1'b1;
                next_state  = RUN;
                next_fz_cnt = '0;
            end
            if (bus.branch_taken || branch_pending) begin
                if_id_fl     = 1'b1;
                id_ex_bub    = 1'b1;
                next_pending = 1'b0;
                flush_inc    = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_bub = 1'b1;
                stall_inc = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_inc),
        .count (flush_q)
    );

    // Drive the bundle outputs.
    always_comb begin
        bus.pc_write_en     = pc_we;
        bus.if_id_write_en  = if_id_we;
        bus.if_id_flush     = if_id_fl;
        bus.id_ex_write_en  = id_ex_we;
        bus.id_ex_bubble    = id_ex_bub;
        bus.ex_mem_write_en = ex_mem_we;
        bus.halted          = (state == HALT);
        bus.stall_cycles    = stall_q;
        bus.flush_count     = flush_q;
    end

endmodule

// File: tb/tb_id_ex_hazard_controller.sv
// Scoreboard bench for id_ex_hazard_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_id_ex_hazard_controller;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;

    id_ex_hazard_controller_if #(.CNT_W(CW)) bus ();

    id_ex_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] idx;
        logic        pc;
        logic        ifid;
        logic        flush;
        logic        idex;
        logic        bubble;
        logic        exmem;
        logic        halted;
        logic [3:0]  stall;
        logic [3:0]  flushc;
    } exp_t;

    exp_t sb[$];

    int unsigned n_vectors    = 0;
    int unsigned n_miscompare = 0;
    int unsigned step_idx     = 0;

    // Reference model state: 0=RUN 1=FREEZE 2=HALT.
    int unsigned m_state;
    logic        m_pend;
    int unsigned m_cnt;
    int unsigned m_stall;
    int unsigned m_flush;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pend  = 1'b0;
        m_cnt   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive one cycle of inputs and push what the outputs must be this cycle.
    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic mb);
        exp_t e;
        logic lu;
        logic sinc;
        @(posedge clk);
        #1;
        reset            = rst;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_uses_rs1  = u1;
        bus.id_uses_rs2  = u2;
        bus.ex_rd        = rd;
        bus.ex_mem_read  = mr;
        bus.branch_taken = br;
        bus.mem_busy     = mb;

        lu = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        e.idx    = 16'(step_idx);
        e.pc     = 1'b1; e.ifid = 1'b1; e.flush = 1'b0;
        e.idex   = 1'b1; e.bubble = 1'b0; e.exmem = 1'b1;
        e.halted = (m_state == 2);
        e.stall  = 4'(m_stall);
        e.flushc = 4'(m_flush);
        sinc = 1'b0;

        if (m_state == 2) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.exmem = 1'b0;
        end else if (mb) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.exmem = 1'b0;
            if (br) m_pend = 1'b1;
            if (m_state == 0) begin
                m_state = 1;
                m_cnt   = 1;
            end else begin
                sinc = 1'b1;
                if (m_cnt == TO) m_state = 2;
                else m_cnt++;
            end
        end else begin
            if (m_state == 1) begin
                sinc    = 1'b1;
                m_state = 0;
                m_cnt   = 0;
            end
            if (br || m_pend) begin
                e.flush = 1'b1; e.bubble = 1'b1;
                m_pend  = 1'b0;
                if (m_flush < CMAX) m_flush++;
            end else if (lu) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.bubble = 1'b1;
                sinc = 1'b1;
            end
        end
        if (sinc && m_stall < CMAX) m_stall++;
        if (rst) model_reset();

        sb.push_back(e);
        step_idx++;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare DUT outputs against the oldest expectation, away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq($sformatf("s%0d.pc_write_en", e.idx),     16'(bus.pc_write_en),     16'(e.pc));
            check_eq($sformatf("s%0d.if_id_write_en", e.idx),  16'(bus.if_id_write_en),  16'(e.ifid));
            check_eq($sformatf("s%0d.if_id_flush", e.idx),     16'(bus.if_id_flush),     16'(e.flush));
            check_eq($sformatf("s%0d.id_ex_write_en", e.idx),  16'(bus.id_ex_write_en),  16'(e.idex));
            check_eq($sformatf("s%0d.id_ex_bubble", e.idx),    16'(bus.id_ex_bubble),    16'(e.bubble));
            check_eq($sformatf("s%0d.ex_mem_write_en", e.idx), 16'(bus.ex_mem_write_en), 16'(e.exmem));
            check_eq($sformatf("s%0d.halted", e.idx),          16'(bus.halted),          16'(e.halted));
            check_eq($sformatf("s%0d.stall_cycles", e.idx),    16'(bus.stall_cycles),    16'(e.stall));
            check_eq($sformatf("s%0d.flush_count", e.idx),     16'(bus.flush_count),     16'(e.flushc));
        end
    end

    initial begin
        int unsigned budget;
        reset            = 1'b1;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_uses_rs1  = 1'b0;
        bus.id_uses_rs2  = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_mem_read  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_busy     = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state plus a single load-use stall.
        idle();
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        idle();
        // x0 destination and an unused rs2 never stall.
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        idle();

        // Branch together with a load-use: flush wins.
        do_reset();
        step(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        idle();

        // Branch arriving as a three-cycle freeze begins.
        do_reset();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Freeze timeout into HALT, HALT ignores inputs, reset recovers.
        do_reset();
        repeat (7) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        idle();
        do_reset();
        idle();

        // Saturation of stall_cycles at 15.
        repeat (20) step(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        idle();

        // Saturation of flush_count.
        do_reset();
        repeat (18) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();

        // Random mix with small register indices to provoke hazards.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 29) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end

        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        check_eq("scoreboard_drain", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_controller.md
Name: id_ex_hazard_controller

Overview:
- Sequences the ID/EX stage of the segmented RISC-V core. Generates write-enable, flush and bubble controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register.
- Handles three cases: load-use stalls, taken-branch flushes and data-memory wait freezes.
- Tracks a freeze timeout and keeps saturating stall/flush performance counters.
- Sits beside the ID/EX wiring designator in the segmented top; its outputs gate the pipeline-register enables.

Parameters:
- MEM_TIMEOUT, 16, cycles mem_busy may stay high in FREEZE before entering HALT; legal range 2..255.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID (IF/ID instruction_out[19:15]).
- id_rs2  in  5  rs2 field of the instruction in ID (instruction_out[24:20]).
- id_uses_rs1  in  1  instruction in ID reads rs1.
- id_uses_rs2  in  1  instruction in ID reads rs2.
- ex_rd  in  5  rd of the instruction in EX (ID/EX instruction_11_7_out).
- ex_mem_read  in  1  instruction in EX is a load.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clears to NOP (0x00000013) on the next edge.
- id_ex_write_en  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads zeroed control (bubble) on the next edge.
- ex_mem_write_en  out  1  EX/MEM load enable.
- halted  out  1  sticky; the controller is in HALT.
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles plus FREEZE cycles.
- flush_count  out  CNT_W  saturating count of applied branch flushes.

Behaviour:
- Reset: state=RUN; branch_pending=0; timeout counter=0; stall_cycles=0; flush_count=0; halted=0.
- Reset priority: reset has priority over all inputs on the same edge. Reset mid-FREEZE or mid-HALT returns to RUN.
- Control outputs are combinational from state, branch_pending and current inputs. Zero added latency.
- Load-use condition: lu = ex_mem_read and ex_rd≠0 and ((id_uses_rs1 and ex_rd==id_rs1) or (id_uses_rs2 and ex_rd==id_rs2)).
- Default (no event): all write_en=1, flush=0, bubble=0.
- RUN priority, highest first:
  1. mem_busy: all four write_en=0, flush=0, bubble=0. Go to FREEZE; timeout counter=1. If branch_taken is also high, set branch_pending=1.
  2. branch_taken or branch_pending: if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (target loads). Clear branch_pending; flush_count+1. Any lu in the same cycle is ignored, because the flushed instruction is dead.
  3. lu: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, id_ex_write_en=1, ex_mem_write_en=1. stall_cycles+1. Exactly one bubble per hazard; the next cycle re-evaluates.
- FREEZE:
  - All write_en=0; no flush or bubble is driven.
  - branch_taken held high keeps branch_pending=1 (idempotent).
  - stall_cycles+1 every cycle.
  - When mem_busy=0: go to RUN; timeout counter=0. That cycle is evaluated with RUN rules, so a pending flush applies immediately.
  - When mem_busy=1 and the counter equals MEM_TIMEOUT: go to HALT.
  - Otherwise the counter increments.
- HALT:
  - All write_en=0; halted=1.
  - Inputs are ignored. Only reset exits.
  - Counters freeze.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- ex_rd==0 never causes a stall.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - typedef enum logic [1:0] {RUN, FREEZE, HALT} hz_state_t
  - constant NOP_INSTR = 32'h00000013
  - constant REG_ZERO = 5'd0
- One sub-module, sat_counter (parameter W; inputs inc and clear), instantiated twice for the performance counters.
- Hazard comparison stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 that cycle; stall_cycles=1; next cycle (ex_mem_read=0) all enables 1.
- x0 and unused operands: ex_rd=0 with id_rs1=0 → no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0 → no stall.
- Branch with simultaneous load-use: branch_taken=1 and lu=1 together → if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_count=1; stall_cycles=0.
- Branch during freeze: mem_busy=1 for 3 cycles with branch_taken=1 in the first → enables 0 for 3 cycles, no flush; first cycle with mem_busy=0 → if_id_flush=1; flush_count=1; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_busy held high → HALT entered on the 5th edge after entry; halted=1; mem_busy=0 afterwards is ignored; reset=1 for one edge → RUN, counters=0, halted=0.
- Saturation: CNT_W=4 with 20 consecutive load-use cycles → stall_cycles stops at 15.
